inst_cache: RTL and testbench

- Direct-mapped, read-only instruction cache that responds to the fetch unit's PC request / instruction-ready handshake.
- Hits are served in 1 cycle.
- On a miss, refills a 4-word line from the memory controller through a word-level request/valid handshake, then returns the requested word.
- Sits between instruction fetch and the memory arbiter.

---
 rtl/inst_cache.sv | 190 +++++++++++++++++++
 tb/tb_inst_cache.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped read-only instruction cache (2^INDEX_WIDTH lines of 4 words), refilled word by word.
// Latency: hit answered the cycle after the request is registered; miss answered the cycle after the 4th refill word.
// Backpressure: rdy low freezes all state (inst_get_ready forced 0); a refill waits indefinitely on mem_word_valid.
// Optional: define ICACHE_STAT_EN to add the hit_count / miss_count outputs.
module inst_cache #(
    parameter int INDEX_WIDTH = 6,
    parameter int LINE_WORDS  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        pc_send_enable,
    input  logic [31:0] pc_to_ic,
    output logic        inst_get_ready,
    output logic [31:0] inst_from_ic,
    input  logic        jump_flag,
    output logic        mem_req_enable,
    output logic [31:0] mem_addr,
    input  logic        mem_word_valid,
    input  logic [31:0] mem_word
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int         LINES     = 1 << INDEX_WIDTH;
    localparam int         TAG_W     = 32 - 4 - INDEX_WIDTH;
    localparam logic [1:0] LAST_WORD = 2'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REFILL, RESP_GAP} state_t;
    state_t state_q, state_d;

    // Line storage: valid bits are reset, tags and data are not.
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES][LINE_WORDS];

    logic        req_q;      // registered fetch request
    logic [31:2] pc_q;       // registered fetch address
    logic [31:2] miss_pc_q;  // address of the line being refilled
    logic [1:0]  word_cnt;
    logic        cancel_q;   // a redirect arrived during the refill
    logic        ready_q;

    logic do_hit, do_miss, word_take, last_word, refill_resp;

    logic [INDEX_WIDTH-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0]       req_tag, fill_tag;
    logic [1:0]             req_off, fill_off;
    logic                   hit;
    logic [31:0]            crit_word;
    logic                   unused_pc;

    assign req_idx  = pc_q[4+INDEX_WIDTH-1:4];
    assign req_tag  = pc_q[31:4+INDEX_WIDTH];
    assign req_off  = pc_q[3:2];
    assign fill_idx = miss_pc_q[4+INDEX_WIDTH-1:4];
    assign fill_tag = miss_pc_q[31:4+INDEX_WIDTH];
    assign fill_off = miss_pc_q[3:2];

    assign hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    // The last word of a line is still on mem_word when the response is registered.
    assign crit_word = (fill_off == LAST_WORD) ? mem_word : data_mem[fill_idx][fill_off];

    assign inst_get_ready = ready_q & rdy;
    assign unused_pc      = ^pc_to_ic[1:0];

    // State register; a freeze holds the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-cycle action strobes.
    always_comb begin
        state_d     = state_q;
        do_hit      = 1'b0;
        do_miss     = 1'b0;
        word_take   = 1'b0;
        last_word   = 1'b0;
        refill_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_q && !jump_flag) begin
                    if (hit) begin
                        do_hit  = 1'b1;
                        state_d = RESP_GAP;
                    end else begin
                        do_miss = 1'b1;
                        state_d = REFILL;
                    end
                end
            end
            REFILL: begin
                if (mem_word_valid && mem_req_enable) begin
                    word_take = 1'b1;
                    if (word_cnt == LAST_WORD) begin
                        last_word = 1'b1;
                        if (cancel_q || jump_flag) begin
                            state_d = IDLE;
                        end else begin
                            refill_resp = 1'b1;
                            state_d     = RESP_GAP;
                        end
                    end
                end
            end
            RESP_GAP: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Request capture, response, refill sequencing and valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q          <= 1'b0;
            pc_q           <= '0;
            miss_pc_q      <= '0;
            ready_q        <= 1'b0;
            inst_from_ic   <= '0;
            mem_req_enable <= 1'b0;
            mem_addr       <= '0;
            word_cnt       <= '0;
            cancel_q       <= 1'b0;
            valid_q        <= '0;
        end else if (rdy) begin
            // Requests are only taken in IDLE, so the held request during RESP_GAP is dropped.
            req_q   <= (state_q == IDLE) && pc_send_enable && !jump_flag;
            pc_q    <= pc_to_ic[31:2];
            ready_q <= do_hit || refill_resp;
            if (do_hit) begin
                inst_from_ic <= data_mem[req_idx][req_off];
            end
            if (do_miss) begin
                miss_pc_q        <= pc_q;
                valid_q[req_idx] <= 1'b0;
                mem_addr         <= {pc_q[31:4], 4'b0000};
                mem_req_enable   <= 1'b1;
                word_cnt         <= '0;
            end
            if (word_take) begin
                word_cnt <= word_cnt + 2'd1;
                mem_addr <= mem_addr + 32'd4;
            end
            if (last_word) begin
                mem_req_enable    <= 1'b0;
                valid_q[fill_idx] <= 1'b1;
                cancel_q          <= 1'b0;
            end else if (state_q == REFILL && jump_flag) begin
                cancel_q <= 1'b1;
            end
            if (refill_resp) begin
                inst_from_ic <= crit_word;
            end
        end
    end

    // Refill data and tag writes.
    always_ff @(posedge clk) begin
        if (!rst && rdy && word_take) begin
            data_mem[fill_idx][word_cnt] <= mem_word;
            if (last_word) begin
                tag_mem[fill_idx] <= fill_tag;
            end
        end
    end

`ifdef ICACHE_STAT_EN
    // Hit responses and refill starts (cancelled ones included); frozen with rdy.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (rdy) begin
            if (do_hit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (do_miss) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: randomized self-checking bench for inst_cache against a line/tag model and a memory image.
// Latency: stimulus driven and outputs sampled on the falling edge of clk.
// Backpressure: exercises rdy freezes, redirects during refill and reset mid-refill.
module tb_inst_cache;
    logic        clk = 1'b0;
    logic        rst, rdy, pc_send_enable, jump_flag, mem_word_valid;
    logic [31:0] pc_to_ic, mem_word;
    logic        inst_get_ready, mem_req_enable;
    logic [31:0] inst_from_ic, mem_addr;
`ifdef ICACHE_STAT_EN
    logic [31:0] hit_count, miss_count;
`endif

    inst_cache dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .pc_send_enable(pc_send_enable), .pc_to_ic(pc_to_ic),
        .inst_get_ready(inst_get_ready), .inst_from_ic(inst_from_ic),
        .jump_flag(jump_flag),
        .mem_req_enable(mem_req_enable), .mem_addr(mem_addr),
        .mem_word_valid(mem_word_valid), .mem_word(mem_word)
`ifdef ICACHE_STAT_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: which tag each line holds, and the backing memory contents.
    bit          model_valid [64];
    logic [21:0] model_tag   [64];
    logic [31:0] mem_img [logic [31:0]];
    int          exp_hits   = 0;
    int          exp_misses = 0;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (!mem_img.exists(w)) mem_img[w] = $urandom;
        return mem_img[w];
    endfunction

    task automatic model_clear();
        foreach (model_valid[i]) model_valid[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // One fetch by a requester that holds pc_send_enable until the cycle after it sees the response.
    task automatic do_fetch(input logic [31:0] pc, input bit do_jump, input bit do_freeze,
                            input bit do_reset, input string name);
        int          idx, cyc, words, delay, resp_cnt, resp_cyc, last_cyc, req_cycles, frz, settle, want;
        logic [21:0] tg;
        bit          exp_hit, drop_next, done, froze, jumped, was_reset;
        logic [31:0] base, resp_word;
        idx = int'(pc[9:4]);
        tg  = pc[31:10];
        base = {pc[31:4], 4'b0000};
        exp_hit = model_valid[idx] && (model_tag[idx] == tg);
        cyc = 0; words = 0; resp_cnt = 0; resp_cyc = -1; last_cyc = -1; req_cycles = 0;
        frz = 0; settle = 0; drop_next = 0; done = 0; froze = 0; jumped = 0; was_reset = 0;
        resp_word = '0;
        if (!exp_hit) exp_misses++;
        @(negedge clk);
        pc_send_enable = 1'b1;
        pc_to_ic = pc;
        delay = $urandom_range(0, 2);
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            mem_word_valid = 1'b0;
            jump_flag = 1'b0;
            if (inst_get_ready) begin
                resp_cnt++;
                if (resp_cnt == 1) begin
                    resp_cyc = cyc;
                    resp_word = inst_from_ic;
                end
                drop_next = 1'b1;
            end else if (drop_next) begin
                pc_send_enable = 1'b0;
                drop_next = 1'b0;
            end
            if (mem_req_enable) req_cycles++;
            if (do_jump && !jumped && words == 2 && last_cyc < cyc) begin
                jump_flag = 1'b1;
                jumped = 1'b1;
                pc_send_enable = 1'b0;
            end
            if (frz > 0) begin
                checks++;
                if (inst_get_ready !== 1'b0 || mem_req_enable !== 1'b1) begin
                    errors++;
                    $display("FAIL %s freeze_hold: ready=%b req=%b, required ready=0 req=1",
                             name, inst_get_ready, mem_req_enable);
                end
                frz--;
                if (frz == 2) begin
                    mem_word_valid = 1'b1;
                    mem_word = 32'hDEAD_BEEF;
                end
                if (frz == 0) rdy = 1'b1;
            end else if (do_freeze && !froze && words == 2 && last_cyc < cyc) begin
                rdy = 1'b0;
                frz = 5;
                froze = 1'b1;
            end else if (do_reset && words == 1 && last_cyc < cyc) begin
                rst = 1'b1;
                pc_send_enable = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                checks++;
                if (mem_req_enable !== 1'b0 || inst_get_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s reset_mid_refill: req=%b ready=%b, required 0 0",
                             name, mem_req_enable, inst_get_ready);
                end
                model_clear();
                was_reset = 1'b1;
                done = 1'b1;
            end else if (mem_req_enable) begin
                if (delay == 0) begin
                    checks++;
                    if (mem_addr !== base + 32'(4 * words)) begin
                        errors++;
                        $display("FAIL %s mem_addr word %0d: got %h, required %h",
                                 name, words, mem_addr, base + 32'(4 * words));
                    end
                    mem_word_valid = 1'b1;
                    mem_word = mem_read(mem_addr);
                    words++;
                    last_cyc = cyc;
                    delay = $urandom_range(0, 2);
                end else begin
                    delay--;
                end
            end
            if (!done && (exp_hit ? (resp_cnt > 0) : (words == 4))) begin
                settle++;
                if (settle >= 4) done = 1'b1;
            end
        end
        rdy = 1'b1;
        pc_send_enable = 1'b0;
        jump_flag = 1'b0;
        mem_word_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: cycles=%0d words=%0d responses=%0d, required completion",
                     name, cyc, words, resp_cnt);
        end else if (!was_reset) begin
            want = jumped ? 0 : 1;
            checks++;
            if (resp_cnt != want) begin
                errors++;
                $display("FAIL %s response_count: got %0d, required %0d", name, resp_cnt, want);
            end
            checks++;
            if ((req_cycles > 0) == exp_hit) begin
                errors++;
                $display("FAIL %s hit_miss: memory traffic=%0d cycles, required %s",
                         name, req_cycles, exp_hit ? "none (hit)" : "refill (miss)");
            end
            if (resp_cnt > 0 && !jumped) begin
                checks++;
                if (resp_word !== mem_read(pc)) begin
                    errors++;
                    $display("FAIL %s data: got %h, required %h", name, resp_word, mem_read(pc));
                end
                want = exp_hit ? 2 : last_cyc + 1;
                checks++;
                if (resp_cyc != want) begin
                    errors++;
                    $display("FAIL %s latency: response at cycle %0d, required %0d", name, resp_cyc, want);
                end
                checks++;
                if (inst_from_ic !== resp_word) begin
                    errors++;
                    $display("FAIL %s hold: inst_from_ic %h, required %h", name, inst_from_ic, resp_word);
                end
            end
            if (exp_hit) begin
                exp_hits++;
            end else begin
                model_valid[idx] = 1'b1;
                model_tag[idx] = tg;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        checks++;
        if (inst_get_ready !== 1'b0 || inst_from_ic !== 32'h0 || mem_req_enable !== 1'b0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: ready=%b inst=%h req=%b addr=%h, required all zero",
                     inst_get_ready, inst_from_ic, mem_req_enable, mem_addr);
        end
`ifdef ICACHE_STAT_EN
        checks++;
        if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_stats: hits=%0d misses=%0d, required 0 0", hit_count, miss_count);
        end
`endif
    endtask

    task automatic test_cold_miss();
        for (int i = 0; i < 4; i++) mem_img[32'h1000 + 32'(4 * i)] = 32'hA0 + 32'(i);
        do_fetch(32'h0000_1008, 0, 0, 0, "cold_miss");
    endtask

    task automatic test_hit_after_fill();
        do_fetch(32'h0000_100C, 0, 0, 0, "hit_after_fill");
    endtask

    task automatic test_conflict();
        do_fetch(32'h0000_1400, 0, 0, 0, "conflict_fill");
    endtask

    task automatic test_jump_refill();
        do_fetch(32'h0000_1000, 1, 0, 0, "jump_refill");
`ifdef ICACHE_STAT_EN
        checks++;
        if (miss_count !== 32'd3) begin
            errors++;
            $display("FAIL miss_count_after_conflict: got %0d, required 3", miss_count);
        end
`endif
        do_fetch(32'h0000_1004, 0, 0, 0, "hit_after_jump");
    endtask

    task automatic test_back_to_back();
        do_fetch(32'h0000_1008, 0, 0, 0, "dup_suppress");
        do_fetch(32'h0000_1000, 0, 0, 0, "b2b_hit0");
        do_fetch(32'h0000_100C, 0, 0, 0, "b2b_hit3");
    endtask

    task automatic test_freeze();
        do_fetch(32'h0000_2230, 0, 1, 0, "freeze_refill");
        do_fetch(32'h0000_2234, 0, 0, 0, "freeze_line_hit");
    endtask

    task automatic test_reset_mid_refill();
        do_fetch(32'h0000_3340, 0, 0, 1, "reset_refill");
        do_fetch(32'h0000_3340, 0, 0, 0, "after_reset_miss");
        do_fetch(32'h0000_3344, 0, 0, 0, "after_reset_hit");
    endtask

    task automatic test_random();
        logic [31:0] pc;
        bit          jmp, frz;
        for (int n = 0; n < 60; n++) begin
            pc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4) |
                 (32'($urandom_range(0, 3)) << 2);
            jmp = ($urandom_range(0, 7) == 0);
            frz = !jmp && ($urandom_range(0, 7) == 0);
            do_fetch(pc, jmp, frz, 0, "random");
        end
    endtask

    task automatic test_stats();
`ifdef ICACHE_STAT_EN
        checks++;
        if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses)) begin
            errors++;
            $display("FAIL stats: hits=%0d misses=%0d, required %0d %0d",
                     hit_count, miss_count, exp_hits, exp_misses);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        pc_send_enable = 1'b0;
        pc_to_ic = '0;
        jump_flag = 1'b0;
        mem_word_valid = 1'b0;
        mem_word = '0;
        test_reset();
        test_cold_miss();
        test_hit_after_fill();
        test_conflict();
        test_jump_refill();
        test_back_to_back();
        test_freeze();
        test_reset_mid_refill();
        test_random();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
